// File: rtl/tag_dispatch_if.sv
// tag_dispatch_if: tag handshake, ingress AXI-Stream and core fan-out bundle.
// Rev 1.0
`default_nettype none

interface tag_dispatch_if #(
  parameter int TAG_SZ     = 5,
  parameter int N_CORES    = 32,
  parameter int DATA_WIDTH = 64
);
  logic [TAG_SZ-1:0]     tag;
  logic                  rdy;
  logic                  ack;
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tlast;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_last;
  logic [N_CORES-1:0]    core_vld;
  logic [N_CORES-1:0]    core_rdy;

  modport slave (
    input  tag, rdy, s_tdata, s_tvalid, s_tlast, core_rdy,
    output ack, s_tready, core_data, core_last, core_vld
  );

  modport master (
    output tag, rdy, s_tdata, s_tvalid, s_tlast, core_rdy,
    input  ack, s_tready, core_data, core_last, core_vld
  );
endinterface

`default_nettype wire

// File: rtl/tag_dispatch.sv
// tag_dispatch: accepts one core tag per packet, then routes that packet to the tagged core.
// Rev 1.0
`default_nettype none

module tag_dispatch #(
  parameter int TAG_SZ     = 5,
  parameter int N_CORES    = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst,
  tag_dispatch_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t                state, next_state;
  logic [TAG_SZ-1:0]     sel;
  logic                  out_vld;
  logic [DATA_WIDTH-1:0] core_data;
  logic                  core_last;

  logic                  ack;
  logic                  s_tready;
  logic                  latch_tag;
  logic                  load;
  logic                  clear;
  logic                  sel_rdy;
  logic                  in_range;
  logic [N_CORES-1:0]    core_vld;

  // Unsigned compare one bit wider so N_CORES == 2**TAG_SZ still fits.
  assign in_range = {1'b0, bus.tag} < (TAG_SZ+1)'(N_CORES);

  // Only the selected core's ready matters; out-of-range sel never streams.
  always_comb begin
    sel_rdy  = 1'b0;
    core_vld = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (sel == TAG_SZ'(i)) begin
        sel_rdy     = bus.core_rdy[i];
        core_vld[i] = out_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ack depends only on state, so no combinational path back into the tree.
  always_comb begin
    next_state = state;
    ack        = 1'b0;
    s_tready   = 1'b0;
    latch_tag  = 1'b0;
    load       = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE: begin
        ack = 1'b1;
        if (bus.rdy) begin
          latch_tag  = 1'b1;
          next_state = in_range ? STREAM : DROP;
        end
      end
      STREAM: begin
        s_tready = !out_vld || sel_rdy;
        load     = bus.s_tvalid && s_tready;
        clear    = out_vld && sel_rdy;
        if (load && bus.s_tlast) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        clear = out_vld && sel_rdy;
        if (!out_vld || sel_rdy) begin
          next_state = IDLE;
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= '0;
      out_vld   <= 1'b0;
      core_data <= '0;
      core_last <= 1'b0;
    end else begin
      if (latch_tag) begin
        sel <= bus.tag;
      end
      if (load) begin
        out_vld   <= 1'b1;
        core_data <= bus.s_tdata;
        core_last <= bus.s_tlast;
      end else if (clear) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.ack       = ack;
  assign bus.s_tready  = s_tready;
  assign bus.core_data = core_data;
  assign bus.core_last = core_last;
  assign bus.core_vld  = core_vld;

endmodule

`default_nettype wire

// File: tb/tb_tag_dispatch.sv
// tb_tag_dispatch: directed stimulus with a queue scoreboard for routed beats.
// Rev 1.0
`default_nettype none

module tb_tag_dispatch;
  localparam int TAG_SZ  = 2;
  localparam int N_CORES = 3;
  localparam int DW      = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tag_dispatch_if #(.TAG_SZ(TAG_SZ), .N_CORES(N_CORES), .DATA_WIDTH(DW)) bus ();

  tag_dispatch #(.TAG_SZ(TAG_SZ), .N_CORES(N_CORES), .DATA_WIDTH(DW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] vld;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    beats_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_tag(input logic [TAG_SZ-1:0] t);
    logic a;
    int   tries;
    a       = 1'b0;
    tries   = 0;
    bus.tag = t;
    bus.rdy = 1'b1;
    while (!a && tries < 50) begin
      @(negedge clk);
      a = bus.ack;
      tick();
      tries++;
    end
    bus.rdy = 1'b0;
    check("tag_accept", a, 1'b1);
  endtask

  task automatic send_pkt(input logic [7:0] d[4], input int n, input logic [2:0] vld,
                          input bit drop, output int stalls);
    logic acc;
    int   tries;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = d[i];
      bus.s_tlast  = (i == n - 1);
      if (!drop) exp_q.push_back(beat_t'{vld: vld, data: d[i], last: (i == n - 1)});
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        @(negedge clk);
        if (drop) check("drop_core_vld", bus.core_vld, 3'b000);
        acc = bus.s_tready;
        tick();
        tries++;
      end
      check("beat_accept", acc, 1'b1);
      stalls += tries - 1;
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int tries;
    tries = 0;
    while (exp_q.size() != 0 && tries < 100) begin
      tick();
      tries++;
    end
    check("drain_queue", exp_q.size(), 0);
  endtask

  // Monitor: pops on every core handshake, checks holding under backpressure.
  logic       prev_pending = 1'b0;
  beat_t      prev_beat;
  always @(negedge clk) begin
    beat_t cur;
    beat_t exp;
    logic  hs;
    if (!rst) begin
      prev_pending = 1'b0;
    end else begin
      cur = beat_t'{vld: bus.core_vld, data: bus.core_data, last: bus.core_last};
      if (prev_pending) check("hold_stable", cur, prev_beat);
      if (|bus.core_vld) begin
        hs = |(bus.core_vld & bus.core_rdy);
        if (!hs) check("bp_s_tready", bus.s_tready, 1'b0);
        if (hs) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
          end else begin
            exp = exp_q.pop_front();
            check("beat", cur, exp);
          end
        end
        prev_pending = !hs;
        prev_beat    = cur;
      end else begin
        prev_pending = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt[4];
    logic [7:0] dpkt[4];
    int         st;
    pkt  = '{8'h11, 8'h22, 8'h33, 8'h44};
    dpkt = '{8'hD1, 8'hD2, 8'hD3, 8'h00};
    bus.tag      = '0;
    bus.rdy      = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.core_rdy = 3'b111;

    #12;
    check("rst_core_vld", bus.core_vld, 3'b000);
    check("rst_s_tready", bus.s_tready, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h11;
    @(negedge clk);
    check("idle_ack", bus.ack, 1'b1);
    check("idle_s_tready", bus.s_tready, 1'b0);
    check("idle_core_vld", bus.core_vld, 3'b000);

    // 4-beat packet to core 2, full throughput
    tick();
    bus.tag = 2'd2;
    bus.rdy = 1'b1;
    @(negedge clk);
    check("t2_ack_T", bus.ack, 1'b1);
    check("t2_pre_tag_s_tready", bus.s_tready, 1'b0);
    tick();
    bus.rdy = 1'b0;
    fork
      send_pkt(pkt, 4, 3'b100, 1'b0, st);
      begin
        @(negedge clk);
        check("t2_ack_T1", bus.ack, 1'b0);
      end
    join
    check("t2_stalls", st, 0);
    @(negedge clk);
    check("t2_ack_drain", bus.ack, 1'b0);
    check("t2_last_vld", bus.core_vld, 3'b100);
    tick();
    @(negedge clk);
    check("t2_ack_back", bus.ack, 1'b1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Same packet with core_rdy[2] toggling
    tick();
    offer_tag(2'd2);
    fork
      send_pkt(pkt, 4, 3'b100, 1'b0, st);
      begin
        repeat (12) begin
          tick();
          bus.core_rdy[2] = ~bus.core_rdy[2];
        end
      end
    join
    bus.core_rdy = 3'b111;
    wait_drain();
    @(negedge clk);
    check("t3_ack_back", bus.ack, 1'b1);

    // Out-of-range tag: packet discarded
    tick();
    offer_tag(2'd3);
    send_pkt(dpkt, 3, 3'b000, 1'b1, st);
    check("drop_stalls", st, 0);
    @(negedge clk);
    check("drop_ack_back", bus.ack, 1'b1);
    check("drop_core_vld_end", bus.core_vld, 3'b000);

    // Back-to-back tags 0 then 1 with 1-beat packets
    tick();
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'hA5;
    bus.s_tlast  = 1'b1;
    bus.tag      = 2'd0;
    bus.rdy      = 1'b1;
    @(negedge clk);
    check("b2b_ack0", bus.ack, 1'b1);
    check("b2b_s_tready0", bus.s_tready, 1'b0);
    tick();
    exp_q.push_back(beat_t'{vld: 3'b001, data: 8'hA5, last: 1'b1});
    bus.tag = 2'd1;
    @(negedge clk);
    check("b2b_ack1", bus.ack, 1'b0);
    check("b2b_s_tready1", bus.s_tready, 1'b1);
    tick();
    bus.s_tdata = 8'h5C;
    @(negedge clk);
    check("b2b_ack2", bus.ack, 1'b0);
    check("b2b_s_tready2", bus.s_tready, 1'b0);
    tick();
    exp_q.push_back(beat_t'{vld: 3'b010, data: 8'h5C, last: 1'b1});
    @(negedge clk);
    check("b2b_ack3", bus.ack, 1'b1);
    check("b2b_s_tready3", bus.s_tready, 1'b0);
    tick();
    bus.rdy = 1'b0;
    @(negedge clk);
    check("b2b_s_tready4", bus.s_tready, 1'b1);
    tick();
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    wait_drain();

    // Asynchronous reset with a beat held in the output register
    tick();
    offer_tag(2'd1);
    bus.core_rdy = 3'b101;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h5A;
    bus.s_tlast  = 1'b0;
    tick();
    bus.s_tvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_vld_before", bus.core_vld, 3'b010);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_vld_async", bus.core_vld, 3'b000);
    check("rst_mid_s_tready", bus.s_tready, 1'b0);
    @(negedge clk);
    tick();
    rst          = 1'b1;
    bus.core_rdy = 3'b111;
    @(negedge clk);
    check("rst_mid_ack", bus.ack, 1'b1);
    check("rst_mid_vld_after", bus.core_vld, 3'b000);

    check("final_queue_empty", exp_q.size(), 0);
    check("beats_routed", beats_seen, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tag_dispatch.md
Name: tag_dispatch

Overview:
- Consumer at the root of the ready-tag arbitration tree. Accepts one core tag per packet over the rdy/ack handshake, then routes the next AXI-Stream packet to the core that tag selects.
- Sits between the ingress AXI-Stream and the parallel filter cores, and closes the loop opened by the tree of arbitration nodes.
- Holds one tag at a time. Releases for the next tag only after the packet's last beat has been delivered.

Parameters:
- TAG_SZ, 5, width of the core tag.
- N_CORES, 32, number of cores. Must satisfy 1 <= N_CORES <= 2**TAG_SZ.
- DATA_WIDTH, 64, width of the stream data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tag  in  TAG_SZ  core index offered by the tree root.
- rdy  in  1  tag valid.
- ack  out  1  tag accepted; transfer occurs when rdy && ack.
- s_tdata  in  DATA_WIDTH  ingress beat.
- s_tvalid  in  1  ingress valid.
- s_tlast  in  1  last beat of packet.
- s_tready  out  1  ingress ready.
- core_data  out  DATA_WIDTH  beat broadcast to all cores.
- core_last  out  1  last flag, broadcast.
- core_vld  out  N_CORES  one-hot valid; only the selected bit is ever set.
- core_rdy  in  N_CORES  per-core ready.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, sel=0, out_vld=0, core_data=0, core_last=0.
  - Outputs: core_vld=0, s_tready=0, ack=1 once released. Because ack=(state==IDLE), ack is high immediately on release.
- ack is a registered-state function only, with no combinational path from rdy. This prevents loops through the tree.
- IDLE:
  - ack=1, s_tready=0.
  - On rdy=1: latch sel<=tag. If tag<N_CORES go to STREAM, else go to DROP.
- STREAM:
  - ack=0.
  - One-entry output register (out_vld, core_data, core_last).
  - s_tready = !out_vld || core_rdy[sel]. This gives full throughput: one beat per cycle when core_rdy[sel] is held high.
  - An ingress beat is accepted on s_tvalid && s_tready and loads the register; out_vld<=1.
  - The register drains on out_vld && core_rdy[sel]. If no new beat is accepted that cycle, out_vld<=0.
  - core_vld = out_vld ? (1<<sel) : 0.
  - Latency: ingress beat to core_vld is 1 cycle.
  - On accepting a beat with s_tlast=1, go to DRAIN.
- DRAIN:
  - s_tready=0, ack=0.
  - Hold the register until out_vld && core_rdy[sel], then out_vld<=0 and go to IDLE.
  - ack rises the cycle after the last beat is consumed. Minimum tag-to-tag spacing for a 1-beat packet is 3 cycles.
- DROP (tag>=N_CORES):
  - s_tready=1, core_vld stays 0, ack=0.
  - Beats are discarded. Go to IDLE on an accepted beat with s_tlast=1.
- Stalls and backpressure:
  - Ingress stall (s_tvalid=0) in STREAM: the register drains normally and the state is held.
  - core_rdy bits other than core_rdy[sel] are ignored.
  - core_rdy[sel]=0 holds core_data/core_last/core_vld stable until the handshake.
- Packets arriving before a tag is accepted are back-pressured (s_tready=0 in IDLE). No beat is ever routed without a tag.
- Single-beat packet (s_tlast on the first beat): STREAM→DRAIN after one beat; legal.
- rdy held high across packets: exactly one tag is consumed per packet, on the IDLE cycle.
- Reset mid-packet:
  - Register contents are lost and core_vld deasserts asynchronously.
  - The remainder of the packet is treated as a new packet once a tag arrives. Upstream is responsible for flushing.
- sel width is TAG_SZ. The range comparison is unsigned against N_CORES.

Test Plan:
- Reset release, rdy=0 → ack=1, s_tready=0, core_vld=0. Assert rst mid-STREAM → core_vld=0 in the same cycle, ack=1 after release.
- TAG_SZ=2, N_CORES=3, DATA_WIDTH=8. tag=2, rdy=1, then 4-beat packet 0x11..0x44, core_rdy=3'b111:
  - ack is high for exactly 1 cycle.
  - core_vld=3'b100 with data 0x11..0x44 on 4 consecutive cycles, core_last on 0x44.
  - ack returns 1 the cycle after the final drain.
- Same packet with core_rdy[2] toggling 1,0,1,0 → no beat lost or duplicated, data stable while stalled, s_tready=0 whenever out_vld=1 and core_rdy[2]=0.
- tag=3 (≥N_CORES), 3-beat packet → s_tready=1 all 3 beats, core_vld=0 throughout, returns to IDLE after the tlast beat.
- rdy=1 with tags 0 then 1 back-to-back, two 1-beat packets:
  - Beat A appears on core_vld=3'b001 and beat B on 3'b010.
  - The second ack occurs 3 cycles after the first.
  - Stream presented before the first tag sees s_tready=0.
